// File: rtl/btb_train_sched_pkg.sv
// Shared types and default sizing for the BTB training scheduler.
package btb_train_sched_pkg;

    localparam int QDEPTH_DEF = 4;
    localparam int IDX_W_DEF  = 5;
    localparam int ADDR_W_DEF = 32;
    localparam int TAG_W_DEF  = ADDR_W_DEF - IDX_W_DEF - 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sched_state_e;

    // Field order of a queued training request; the top keeps the same layout at its own widths.
    typedef struct packed {
        logic [TAG_W_DEF-1:0]  tag;
        logic [IDX_W_DEF-1:0]  idx;
        logic [ADDR_W_DEF-1:0] target;
        logic                  taken;
    } train_entry_t;

endpackage

// File: rtl/btb_train_fifo.sv
// Synchronous FIFO for BTB training requests. A clear drops all contents; a push in the same
// cycle as a clear lands as the sole entry. Push on full is accepted when a pop happens too.
module btb_train_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          full
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_pop;
    logic          do_push;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;

    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & (count != '0);
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    assign mem_we    = clr ? push : do_push;
    assign mem_waddr = clr ? '0 : wr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= AW'(push);
            count  <= CW'(push);
        end else begin
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: nothing reads a slot before it is written.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= din;
    end

endmodule

// File: rtl/btb_train_sched.sv
// BTB write-port scheduler: queues EX training requests, runs invalidate sweeps, drives redirect.
// Optional BTB_TRAIN_STATS_EN adds saturating mispredict/drop counters.
module btb_train_sched
    import btb_train_sched_pkg::*;
#(
    parameter int QDEPTH  = QDEPTH_DEF,
    parameter int IDX_W   = IDX_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    localparam int TAG_W  = ADDR_W - IDX_W - 2,
    localparam int CW     = $clog2(QDEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_ex,
    input  logic              update_btb_ex,
    input  logic              ex_branch_taken,
    input  logic [ADDR_W-1:0] pc_ex,
    input  logic [ADDR_W-1:0] jump_addr_ex,
    input  logic              modify_pc_ex,
    input  logic [ADDR_W-1:0] update_pc_ex,
    input  logic              flush_btb_req,
    input  logic              btb_wready,
    output logic              btb_we,
    output logic [IDX_W-1:0]  btb_widx,
    output logic [TAG_W-1:0]  btb_wtag,
    output logic [ADDR_W-1:0] btb_wtarget,
    output logic              btb_wtaken,
    output logic              btb_wvalid,
    output logic              pc_redirect,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic [CW-1:0]     q_count,
    output logic              q_full,
    output logic              sweep_busy
`ifdef BTB_TRAIN_STATS_EN
    ,
    output logic [15:0]       mispredict_cnt,
    output logic [15:0]       drop_cnt
`endif
);

    localparam int EW = TAG_W + IDX_W + ADDR_W + 1;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [IDX_W-1:0]  idx;
        logic [ADDR_W-1:0] target;
        logic              taken;
    } entry_t;

    sched_state_e     state;
    logic [IDX_W-1:0] sidx;
    entry_t           enq;
    entry_t           head;
    logic [EW-1:0]    head_raw;
    logic             push;
    logic             pop;
    logic             sweeping;
    logic             redirect;
    logic             unused_pc_lsb;

    assign unused_pc_lsb = ^pc_ex[1:0];

    assign redirect    = modify_pc_ex & ~stall_ex;
    assign pc_redirect = redirect;
    assign flush_if_id = redirect;
    assign flush_id_ex = redirect;
    assign redirect_pc = update_pc_ex;

    assign push = update_btb_ex & ~stall_ex;
    assign enq  = '{tag:    pc_ex[ADDR_W-1:IDX_W+2],
                    idx:    pc_ex[IDX_W+1:2],
                    target: jump_addr_ex,
                    taken:  ex_branch_taken};

    assign sweeping   = (state == SWEEP);
    assign sweep_busy = sweeping;
    assign btb_we     = sweeping ? btb_wready : (btb_wready & (q_count != '0));
    assign pop        = btb_we & ~sweeping;
    assign head       = entry_t'(head_raw);

    btb_train_fifo #(
        .DEPTH (QDEPTH),
        .W     (EW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush_btb_req),
        .push  (push),
        .pop   (pop),
        .din   (enq),
        .dout  (head_raw),
        .count (q_count),
        .full  (q_full)
    );

    // Write fields are held at zero whenever no write is issued.
    always_comb begin
        btb_widx    = '0;
        btb_wtag    = '0;
        btb_wtarget = '0;
        btb_wtaken  = 1'b0;
        btb_wvalid  = 1'b0;
        if (btb_we) begin
            if (sweeping) begin
                btb_widx = sidx;
            end else begin
                btb_widx    = head.idx;
                btb_wtag    = head.tag;
                btb_wtarget = head.target;
                btb_wtaken  = head.taken;
                btb_wvalid  = 1'b1;
            end
        end
    end

    // Sweep ends after the write at the last index; the index wraps to 0 on its own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sidx  <= '0;
        end else if (flush_btb_req) begin
            state <= SWEEP;
            sidx  <= '0;
        end else if (sweeping && btb_wready) begin
            sidx <= sidx + IDX_W'(1);
            if (sidx == '1) state <= IDLE;
        end
    end

`ifdef BTB_TRAIN_STATS_EN
    logic drop;
    // A flush keeps the same-cycle request, so it can never be a drop.
    assign drop = push & q_full & ~pop & ~flush_btb_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict_cnt <= '0;
            drop_cnt       <= '0;
        end else begin
            if (redirect && mispredict_cnt != 16'hffff) mispredict_cnt <= mispredict_cnt + 16'd1;
            if (drop && drop_cnt != 16'hffff)           drop_cnt       <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_btb_train_sched.sv
// Randomised and directed bench for btb_train_sched against a queue-based behavioural model.
module tb_btb_train_sched;

    localparam int QD = 4;
    localparam int IW = 5;
    localparam int AW = 32;
    localparam int TW = AW - IW - 2;
    localparam int NENT = 1 << IW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall_ex = 1'b0, update_btb_ex = 1'b0, ex_branch_taken = 1'b0;
    logic [AW-1:0] pc_ex = '0, jump_addr_ex = '0, update_pc_ex = '0;
    logic          modify_pc_ex = 1'b0, flush_btb_req = 1'b0, btb_wready = 1'b0;
    logic          btb_we, btb_wtaken, btb_wvalid, pc_redirect, flush_if_id, flush_id_ex;
    logic [IW-1:0] btb_widx;
    logic [TW-1:0] btb_wtag;
    logic [AW-1:0] btb_wtarget, redirect_pc;
    logic [2:0]    q_count;
    logic          q_full, sweep_busy;
`ifdef BTB_TRAIN_STATS_EN
    logic [15:0]   mispredict_cnt, drop_cnt;
`endif

    btb_train_sched #(.QDEPTH(QD), .IDX_W(IW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .stall_ex(stall_ex), .update_btb_ex(update_btb_ex),
        .ex_branch_taken(ex_branch_taken), .pc_ex(pc_ex), .jump_addr_ex(jump_addr_ex),
        .modify_pc_ex(modify_pc_ex), .update_pc_ex(update_pc_ex), .flush_btb_req(flush_btb_req),
        .btb_wready(btb_wready), .btb_we(btb_we), .btb_widx(btb_widx), .btb_wtag(btb_wtag),
        .btb_wtarget(btb_wtarget), .btb_wtaken(btb_wtaken), .btb_wvalid(btb_wvalid),
        .pc_redirect(pc_redirect), .redirect_pc(redirect_pc), .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex), .q_count(q_count), .q_full(q_full), .sweep_busy(sweep_busy)
`ifdef BTB_TRAIN_STATS_EN
        , .mispredict_cnt(mispredict_cnt), .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(string name, longint unsigned act, longint unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: a plain queue of pending writes plus a "sweep in progress" position.
    typedef struct {
        logic [TW-1:0] tag;
        logic [IW-1:0] idx;
        logic [AW-1:0] target;
        logic          taken;
    } ent_t;

    ent_t mq[$];
    bit   m_sweep = 0;
    int   m_pos = 0;
    int   m_mis = 0;
    int   m_drop = 0;

    always @(negedge clk) begin
        bit   red, ewe, psh;
        ent_t e;
        red = modify_pc_ex && !stall_ex;
        chk("pc_redirect", pc_redirect, red);
        chk("flush_if_id", flush_if_id, red);
        chk("flush_id_ex", flush_id_ex, red);
        chk("redirect_pc", redirect_pc, update_pc_ex);
        if (!rst_n) begin
            mq.delete();
            m_sweep = 0; m_pos = 0; m_mis = 0; m_drop = 0;
            chk("rst_we", btb_we, 0);
            chk("rst_wfields", {btb_widx, btb_wtag, btb_wtarget, btb_wtaken, btb_wvalid} == '0, 1);
            chk("rst_q_count", q_count, 0);
            chk("rst_q_full", q_full, 0);
            chk("rst_sweep_busy", sweep_busy, 0);
`ifdef BTB_TRAIN_STATS_EN
            chk("rst_stats", {mispredict_cnt, drop_cnt}, 0);
`endif
        end else begin
            ewe = m_sweep ? btb_wready : (btb_wready && mq.size() > 0);
            chk("btb_we", btb_we, ewe);
            chk("q_count", q_count, mq.size());
            chk("q_full", q_full, mq.size() == QD);
            chk("sweep_busy", sweep_busy, m_sweep);
            if (ewe && m_sweep) begin
                chk("sweep_widx", btb_widx, m_pos);
                chk("sweep_wvalid", btb_wvalid, 0);
                chk("sweep_fields", {btb_wtag, btb_wtarget, btb_wtaken}, 0);
            end else if (ewe) begin
                chk("widx", btb_widx, mq[0].idx);
                chk("wtag", btb_wtag, mq[0].tag);
                chk("wtarget", btb_wtarget, mq[0].target);
                chk("wtaken", btb_wtaken, mq[0].taken);
                chk("wvalid", btb_wvalid, 1);
            end
`ifdef BTB_TRAIN_STATS_EN
            chk("mispredict_cnt", mispredict_cnt, m_mis);
            chk("drop_cnt", drop_cnt, m_drop);
`endif
            // advance the model by the edge that follows
            psh = update_btb_ex && !stall_ex;
            e = '{pc_ex[AW-1:IW+2], pc_ex[IW+1:2], jump_addr_ex, ex_branch_taken};
            if (red && m_mis < 65535) m_mis++;
            if (flush_btb_req) begin
                mq.delete();
                if (psh) mq.push_back(e);
                m_sweep = 1; m_pos = 0;
            end else begin
                if (m_sweep && btb_wready) begin
                    m_pos++;
                    if (m_pos == NENT) begin m_sweep = 0; m_pos = 0; end
                end else if (ewe) begin
                    void'(mq.pop_front());
                end
                if (psh) begin
                    if (mq.size() < QD) mq.push_back(e);
                    else if (m_drop < 65535) m_drop++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle_in();
        stall_ex = 0; update_btb_ex = 0; ex_branch_taken = 0; modify_pc_ex = 0; flush_btb_req = 0;
    endtask

    initial begin
        int  busy_n, sw_n, first_idx;
        bit  done, restarted, seen_first;

        // reset
        rst_n = 0;
        repeat (2) @(negedge clk);
        chk("lit_rst_we", btb_we, 0);
        chk("lit_rst_q_count", q_count, 0);
        step(); rst_n = 1;

        // single request: pc 0x1040 -> idx 0x10, tag 0x20
        step();
        btb_wready = 1; update_btb_ex = 1; pc_ex = 32'h0000_1040;
        jump_addr_ex = 32'h0000_2000; ex_branch_taken = 1;
        step(); idle_in();
        @(negedge clk);
        chk("lit_t1_we", btb_we, 1);
        chk("lit_t1_idx", btb_widx, 5'h10);
        chk("lit_t1_tag", btb_wtag, 25'h20);
        chk("lit_t1_target", btb_wtarget, 32'h2000);
        chk("lit_t1_valid", btb_wvalid, 1);
        step(); @(negedge clk);
        chk("lit_t1_qcount", q_count, 0);

        // five requests with the port busy: fifth dropped, then four in order
        step(); btb_wready = 0;
        for (int i = 0; i < 5; i++) begin
            update_btb_ex = 1; pc_ex = (i << 7) | ((i + 1) << 2); jump_addr_ex = 32'h3000 + i;
            step();
        end
        idle_in();
        @(negedge clk);
        chk("lit_t2_full", q_full, 1);
        chk("lit_t2_count", q_count, 4);
`ifdef BTB_TRAIN_STATS_EN
        chk("lit_t2_drop", drop_cnt, 1);
`endif
        step(); btb_wready = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("lit_t2_we", btb_we, 1);
            chk("lit_t2_order", btb_widx, i + 1);
            step();
        end

        // redirect path, same cycle
        modify_pc_ex = 1; update_pc_ex = 32'h104; stall_ex = 0; #1;
        chk("lit_t3_redirect", {pc_redirect, flush_if_id, flush_id_ex}, 3'b111);
        chk("lit_t3_pc", redirect_pc, 32'h104);
        stall_ex = 1; #1;
        chk("lit_t3_stalled", {pc_redirect, flush_if_id, flush_id_ex}, 3'b000);
        step(); idle_in();

        // sweep with two stale entries; one request enqueued mid-sweep
        btb_wready = 0;
        for (int i = 0; i < 2; i++) begin
            update_btb_ex = 1; pc_ex = 32'h800 + (i << 2); step();
        end
        idle_in(); btb_wready = 1; flush_btb_req = 1;
        step(); flush_btb_req = 0;
        busy_n = 0; sw_n = 0; done = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (c == 0) chk("lit_t4_cleared", q_count, 0);
            if (!sweep_busy) begin done = 1; break; end
            busy_n++;
            if (btb_we && !btb_wvalid) sw_n++;
            step();
            update_btb_ex = (c == 10); pc_ex = 32'h5554; jump_addr_ex = 32'h9000;
        end
        if (!done) chk("t4_timeout", 0, 1);
        chk("lit_t4_busy_cycles", busy_n, 32);
        chk("lit_t4_sweep_writes", sw_n, 32);
        chk("lit_t4_after_we", {btb_we, btb_wvalid}, 2'b11);
        chk("lit_t4_after_idx", btb_widx, 5'h15);
        step(); idle_in();

        // restart the sweep when it reaches index 17 (port held busy that cycle)
        flush_btb_req = 1; step(); flush_btb_req = 0;
        sw_n = 0; done = 0; restarted = 0; seen_first = 0; first_idx = -1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!sweep_busy) begin done = 1; break; end
            if (btb_we && !btb_wvalid) begin
                sw_n++;
                if (restarted && !seen_first) begin seen_first = 1; first_idx = btb_widx; end
            end
            step();
            if (sw_n == 17 && !restarted) begin
                btb_wready = 0; flush_btb_req = 1; restarted = 1;
            end else begin
                btb_wready = 1; flush_btb_req = 0;
            end
        end
        if (!done) chk("t5_timeout", 0, 1);
        chk("lit_t5_sweep_writes", sw_n, 17 + 32);
        chk("lit_t5_restart_idx", first_idx, 0);
        step(); idle_in();

        // reset mid-sweep with three queued requests
        flush_btb_req = 1; step(); flush_btb_req = 0; btb_wready = 0;
        for (int i = 0; i < 3; i++) begin
            update_btb_ex = 1; pc_ex = 32'hA00 + (i << 2); step();
        end
        idle_in();
        @(negedge clk);
        chk("lit_t6_queued", q_count, 3);
        chk("lit_t6_busy", sweep_busy, 1);
        step(); rst_n = 0;
        @(negedge clk);
        chk("lit_t6_rst_count", q_count, 0);
        chk("lit_t6_rst_busy", sweep_busy, 0);
        step(); rst_n = 1;
        @(negedge clk);
        chk("lit_t6_idle", {sweep_busy, btb_we}, 0);

        // randomised traffic
        for (int c = 0; c < 3000; c++) begin
            step();
            rst_n           = ($urandom_range(0, 999) != 0);
            stall_ex        = ($urandom_range(0, 4) == 0);
            update_btb_ex   = $urandom_range(0, 1);
            ex_branch_taken = $urandom_range(0, 1);
            pc_ex           = $urandom;
            jump_addr_ex    = $urandom;
            modify_pc_ex    = ($urandom_range(0, 3) == 0);
            update_pc_ex    = $urandom;
            flush_btb_req   = ($urandom_range(0, 149) == 0);
            btb_wready      = ($urandom_range(0, 9) < 7);
        end
        step(); idle_in(); rst_n = 1;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
